// File: rtl/jtframe_dwnld_sched_pkg.sv
// Shared types for the ROM download scheduler: handshake states, FIFO entry layout
// and the active-low byte-mask encodings used on the SDRAM write port.
package jtframe_dwnld_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } dwnld_state_t;

  // FIFO entries carry word addresses up to 22 bits wide
  localparam int ENTRY_AW = 22;

  typedef struct packed {
    logic [ENTRY_AW-1:0] addr;
    logic [15:0]         data;
    logic [1:0]          mask;
  } fifo_entry_t;

  localparam logic [1:0] MASK_BOTH = 2'b00;
  localparam logic [1:0] MASK_LO   = 2'b10;
  localparam logic [1:0] MASK_HI   = 2'b01;

  // A lone byte lands in the half selected by its address parity
  function automatic fifo_entry_t single_entry(input logic [ENTRY_AW-1:0] addr,
                                               input logic [7:0] data, input logic odd);
    fifo_entry_t e;
    e.addr = addr;
    e.data = odd ? {data, 8'h00} : {8'h00, data};
    e.mask = odd ? MASK_HI : MASK_LO;
    return e;
  endfunction

endpackage

// File: rtl/jtframe_dwnld_sched_if.sv
// SDRAM programming port: the scheduler drives a held request until the memory acks it.
interface jtframe_dwnld_sched_if #(parameter int AW = 22);
  logic [AW-1:0] prog_addr;
  logic [15:0]   prog_data;
  logic [1:0]    prog_mask;
  logic          prog_we;
  logic          sdram_ack;

  modport master (output prog_addr, output prog_data, output prog_mask, output prog_we,
                  input sdram_ack);
  modport slave  (input prog_addr, input prog_data, input prog_mask, input prog_we,
                  output sdram_ack);
endinterface

// File: rtl/jtframe_dwnld_sched_fifo.sv
// Small synchronous word FIFO; pushes into a full FIFO and pops from an empty one are ignored.
module jtframe_dwnld_fifo
  import jtframe_dwnld_pkg::*;
#(
  parameter int FIFO_AW = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  fifo_entry_t        din,
  input  logic               pop,
  output fifo_entry_t        dout,
  output logic               full,
  output logic               empty,
  output logic [FIFO_AW:0]   count
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]   CNT_ONE = (FIFO_AW + 1)'(1);

  fifo_entry_t        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_r;
  logic [FIFO_AW-1:0] rd_ptr_r;
  logic [FIFO_AW:0]   count_r;
  logic               wr_en_s;
  logic               rd_en_s;

  assign full    = (count_r == (FIFO_AW + 1)'(DEPTH));
  assign empty   = (count_r == '0);
  assign count   = count_r;
  assign wr_en_s = push && !full;
  assign rd_en_s = pop && !empty;
  assign dout    = mem[rd_ptr_r];

  // Storage array, written only on accepted pushes
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[wr_ptr_r] <= din;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (rd_en_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({wr_en_s, rd_en_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/jtframe_dwnld_sched.sv
// Download scheduler: packs ioctl bytes into SDRAM words, sequences the SDRAM write
// handshake, forwards PROM-region bytes and throttles the loader.
module jtframe_dwnld_sched
  import jtframe_dwnld_pkg::*;
#(
  parameter int          AW         = 22,
  parameter logic [24:0] PROM_START = ~25'd0,
  parameter int          FIFO_AW    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  downloading,
  input  logic [24:0]           ioctl_addr,
  input  logic [7:0]            ioctl_data,
  input  logic                  ioctl_wr,
  output logic                  ioctl_wait,
  jtframe_dwnld_sched_if.master prog,
  output logic [21:0]           prom_addr,
  output logic [7:0]            prom_data,
  output logic                  prom_we,
  output logic                  busy,
  output logic                  ovf
);

  localparam int   DEPTH   = 1 << FIFO_AW;
  localparam logic PROM_EN = (PROM_START != {25{1'b1}});

  dwnld_state_t     state_r;
  logic             pend_valid_r, pend_odd_r, flush_next_r;
  logic [AW-1:0]    pend_word_r;
  logic [7:0]       pend_data_r;
  logic             pend_valid_nx, pend_odd_nx, flush_nx;
  logic [AW-1:0]    pend_word_nx;
  logic [7:0]       pend_data_nx;
  logic             accept_s, is_prom_s, held_s, push_s, pop_s;
  logic [AW-1:0]    word_s;
  fifo_entry_t      pend_entry_s, push_entry_s, head_s;
  logic             fifo_full_s, fifo_empty_s;
  logic [FIFO_AW:0] fifo_count_s;

  assign accept_s     = ioctl_wr && downloading;
  assign is_prom_s    = PROM_EN && (ioctl_addr >= PROM_START);
  assign word_s       = ioctl_addr[AW:1];
  assign pend_entry_s = single_entry(ENTRY_AW'(pend_word_r), pend_data_r, pend_odd_r);
  assign pop_s        = (state_r == REQ) && prog.sdram_ack;
  assign ioctl_wait   = (fifo_count_s >= (FIFO_AW + 1)'(DEPTH - 1)) || flush_next_r;

  // Byte packing: decides the single FIFO push of this cycle and the next pending byte
  always_comb begin
    push_s        = 1'b0;
    push_entry_s  = pend_entry_s;
    pend_valid_nx = pend_valid_r;
    pend_odd_nx   = pend_odd_r;
    pend_word_nx  = pend_word_r;
    pend_data_nx  = pend_data_r;
    flush_nx      = 1'b0;
    held_s        = pend_valid_r;
    // A deferred odd byte, or anything left when the window closes, goes out now
    if (pend_valid_r && (flush_next_r || !downloading)) begin
      push_s        = 1'b1;
      pend_valid_nx = 1'b0;
      held_s        = 1'b0;
    end else begin
      held_s        = pend_valid_r;
    end
    if (accept_s && is_prom_s) begin
      push_s        = push_s || held_s;
      pend_valid_nx = 1'b0;
    end else if (accept_s && !ioctl_addr[0]) begin
      push_s        = push_s || held_s;
      pend_valid_nx = 1'b1;
      pend_odd_nx   = 1'b0;
      pend_word_nx  = word_s;
      pend_data_nx  = ioctl_data;
    end else if (accept_s) begin
      if (held_s && !pend_odd_r && (pend_word_r == word_s)) begin
        push_s        = 1'b1;
        push_entry_s  = '{addr: ENTRY_AW'(word_s), data: {ioctl_data, pend_data_r},
                          mask: MASK_BOTH};
        pend_valid_nx = 1'b0;
      end else if (held_s || push_s) begin
        // Push slot already taken: park the odd byte and send it next cycle
        push_s        = 1'b1;
        pend_valid_nx = 1'b1;
        pend_odd_nx   = 1'b1;
        pend_word_nx  = word_s;
        pend_data_nx  = ioctl_data;
        flush_nx      = 1'b1;
      end else begin
        push_s        = 1'b1;
        push_entry_s  = single_entry(ENTRY_AW'(word_s), ioctl_data, 1'b1);
      end
    end else begin
      flush_nx      = 1'b0;
    end
  end

  // Pending byte register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid_r <= 1'b0;
      pend_odd_r   <= 1'b0;
      pend_word_r  <= '0;
      pend_data_r  <= 8'h00;
      flush_next_r <= 1'b0;
    end else begin
      pend_valid_r <= pend_valid_nx;
      pend_odd_r   <= pend_odd_nx;
      pend_word_r  <= pend_word_nx;
      pend_data_r  <= pend_data_nx;
      flush_next_r <= flush_nx;
    end
  end

  jtframe_dwnld_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .din   (push_entry_s),
    .pop   (pop_s),
    .dout  (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // SDRAM handshake: request held until acked, then one idle gap cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      prog.prog_we   <= 1'b0;
      prog.prog_addr <= '0;
      prog.prog_data <= 16'h0000;
      prog.prog_mask <= 2'b00;
    end else begin
      case (state_r)
        IDLE: begin
          if (!fifo_empty_s) begin
            prog.prog_addr <= AW'(head_s.addr);
            prog.prog_data <= head_s.data;
            prog.prog_mask <= head_s.mask;
            prog.prog_we   <= 1'b1;
            state_r        <= REQ;
          end
        end
        REQ: begin
          if (prog.sdram_ack) begin
            prog.prog_we <= 1'b0;
            state_r      <= GAP;
          end
        end
        GAP:     state_r <= IDLE;
        default: begin
          prog.prog_we <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  // PROM write pulse, one cycle after the byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prom_we   <= 1'b0;
      prom_addr <= 22'd0;
      prom_data <= 8'h00;
    end else begin
      prom_we <= accept_s && is_prom_s;
      if (accept_s && is_prom_s) begin
        prom_addr <= ioctl_addr[21:0];
        prom_data <= ioctl_data;
      end
    end
  end

  // Status flags: busy until everything has drained, sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      if (accept_s) begin
        busy <= 1'b1;
      end else if (!downloading && !pend_valid_r && fifo_empty_s && (state_r == IDLE)) begin
        busy <= 1'b0;
      end
      if (push_s && fifo_full_s) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jtframe_dwnld_sched.sv
// Self-checking bench: directed scenarios with literal expectations, then random
// download bursts compared every cycle against a queue-based reference model.
module tb_jtframe_dwnld_sched;
  import jtframe_dwnld_pkg::*;

  localparam int          AW     = 22;
  localparam logic [24:0] PSTART = 25'h100;

  logic        clk = 1'b0, rst_n = 1'b0, downloading = 1'b0, ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_data = '0;
  logic        ioctl_wait, prom_we, busy, ovf;
  logic [21:0] prom_addr;
  logic [7:0]  prom_data;
  logic        ack = 1'b0, ack_en = 1'b1, spur = 1'b0, cmp_en = 1'b0;
  int          ack_dly = 0, wcnt = 0;
  int          checks = 0, errors = 0;

  jtframe_dwnld_sched_if #(.AW(AW)) prog ();
  assign prog.sdram_ack = ack;

  jtframe_dwnld_sched #(.AW(AW), .PROM_START(PSTART), .FIFO_AW(2)) dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading), .ioctl_addr(ioctl_addr),
    .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr), .ioctl_wait(ioctl_wait), .prog(prog),
    .prom_addr(prom_addr), .prom_data(prom_data), .prom_we(prom_we), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [21:0] addr; logic [15:0] data; logic [1:0] mask; } ment_t;
  ment_t       mq[$];
  logic        m_pv, m_podd, m_fn, m_req, m_cool, m_busy, m_ovf, m_prom_we;
  logic [21:0] m_pword, m_prom_addr;
  logic [7:0]  m_pdata, m_prom_data;

  function automatic ment_t one(input logic [21:0] w, input logic [7:0] d, input logic odd);
    ment_t e;
    e.addr = w;
    e.data = odd ? {d, 8'h00} : {8'h00, d};
    e.mask = odd ? 2'b01 : 2'b10;
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic acc, have, vac;
    int sz0;
    ment_t e;
    logic [21:0] w;
    if (!rst_n) begin
      mq.delete();
      m_pv = 0; m_podd = 0; m_fn = 0; m_req = 0; m_cool = 0; m_busy = 0; m_ovf = 0;
      m_prom_we = 0; m_pword = 0; m_pdata = 0; m_prom_addr = 0; m_prom_data = 0;
    end else begin
      sz0  = mq.size();
      acc  = ioctl_wr && downloading;
      have = 0;
      e    = '0;
      w    = ioctl_addr[22:1];
      if (acc) m_busy = 1;
      else if (!downloading && !m_pv && sz0 == 0 && !m_req && !m_cool) m_busy = 0;
      m_prom_we = 0;
      vac = m_pv && (m_fn || !downloading);
      if (vac) begin have = 1; e = one(m_pword, m_pdata, m_podd); m_pv = 0; m_fn = 0; end
      if (acc) begin
        if (ioctl_addr >= PSTART) begin
          m_prom_we = 1; m_prom_addr = ioctl_addr[21:0]; m_prom_data = ioctl_data;
          if (m_pv) begin have = 1; e = one(m_pword, m_pdata, m_podd); m_pv = 0; end
        end else if (!ioctl_addr[0]) begin
          if (m_pv) begin have = 1; e = one(m_pword, m_pdata, m_podd); end
          m_pv = 1; m_podd = 0; m_pword = w; m_pdata = ioctl_data; m_fn = 0;
        end else if (m_pv && !m_podd && m_pword == w) begin
          have = 1; e = '{w, {ioctl_data, m_pdata}, 2'b00}; m_pv = 0;
        end else if (m_pv || have) begin
          if (m_pv) begin have = 1; e = one(m_pword, m_pdata, m_podd); end
          m_pv = 1; m_podd = 1; m_pword = w; m_pdata = ioctl_data; m_fn = 1;
        end else begin
          have = 1; e = one(w, ioctl_data, 1'b1);
        end
      end
      if (m_req) begin
        if (ack) begin
          m_req = 0; m_cool = 1;
          void'(mq.pop_front());
        end
      end else if (m_cool) m_cool = 0;
      else if (sz0 > 0) m_req = 1;
      if (have) begin
        if (sz0 == 4) m_ovf = 1;
        else mq.push_back(e);
      end
    end
  end

  // ---------------- per-cycle compare + request monitor ----------------
  ment_t recs[$];
  ment_t proms[$];
  logic  we_prev = 1'b0;

  always @(negedge clk) begin : compare
    logic [15:0] bm;
    if (rst_n && cmp_en) begin
      chk("prog_we", prog.prog_we, m_req);
      if (m_req && prog.prog_we && mq.size() > 0) begin
        bm = {{8{~mq[0].mask[1]}}, {8{~mq[0].mask[0]}}};
        chk("prog_addr", prog.prog_addr, mq[0].addr);
        chk("prog_mask", prog.prog_mask, mq[0].mask);
        chk("prog_data", prog.prog_data & bm, mq[0].data & bm);
      end
      chk("ioctl_wait", ioctl_wait, (mq.size() >= 3) || m_fn);
      chk("busy", busy, m_busy);
      chk("ovf", ovf, m_ovf);
      chk("prom_we", prom_we, m_prom_we);
      if (m_prom_we) begin
        chk("prom_addr", prom_addr, m_prom_addr);
        chk("prom_data", prom_data, m_prom_data);
      end
    end
    if (prog.prog_we && !we_prev) recs.push_back('{prog.prog_addr, prog.prog_data, prog.prog_mask});
    if (prom_we) proms.push_back('{prom_addr, {8'h00, prom_data}, 2'b00});
    we_prev = prog.prog_we;
  end

  // SDRAM responder: ack after ack_dly cycles of request, optional stray acks otherwise
  always @(negedge clk) begin
    if (!ack_en) begin
      ack = 0; wcnt = 0;
    end else if (prog.prog_we) begin
      if (wcnt >= ack_dly) begin ack = 1; wcnt = 0; end
      else begin ack = 0; wcnt++; end
    end else begin
      wcnt = 0;
      ack = spur && ($urandom_range(0, 3) == 0);
    end
  end

  task automatic send(input logic [24:0] a, input logic [7:0] d, input logic obey);
    int n = 0;
    @(negedge clk);
    while (obey && ioctl_wait && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("wait_timeout", 32'd1, 32'd0);
    ioctl_addr = a; ioctl_data = d; ioctl_wr = 1;
    @(negedge clk);
    ioctl_wr = 0;
  endtask

  task automatic finish_dl();
    int n = 0;
    @(negedge clk);
    downloading = 0;
    while (busy && n < 300) begin @(negedge clk); n++; end
    chk("drain_timeout", busy, 32'd0);
  endtask

  task automatic wait_reqs(input int cnt);
    int n = 0;
    while (recs.size() < cnt && n < 300) begin @(negedge clk); n++; end
    chk("req_timeout", (recs.size() >= cnt), 32'd1);
  endtask

  initial begin
    #3000000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [24:0] cur, a;
    int nb;
    logic seen4;
    repeat (3) @(negedge clk);
    chk("rst_prog_we", prog.prog_we, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_ovf", ovf, 32'd0);
    chk("rst_wait", ioctl_wait, 32'd0);
    chk("rst_prom_we", prom_we, 32'd0);
    #3 rst_n = 1;
    cmp_en = 1;

    // pair 0x00/0x01
    recs.delete(); ack_dly = 2; downloading = 1;
    send(25'h000, 8'hAA, 1); send(25'h001, 8'hBB, 1);
    wait_reqs(1);
    chk("s1_busy_hi", busy, 32'd1);
    finish_dl();
    chk("s1_nreq", recs.size(), 32'd1);
    if (recs.size() >= 1) begin
      chk("s1_addr", recs[0].addr, 32'h0);
      chk("s1_data", recs[0].data, 32'hBBAA);
      chk("s1_mask", recs[0].mask, 32'h0);
    end

    // two lone even bytes
    recs.delete(); downloading = 1;
    send(25'h010, 8'hAA, 1); send(25'h020, 8'h11, 1);
    finish_dl();
    chk("s2_nreq", recs.size(), 32'd2);
    if (recs.size() >= 2) begin
      chk("s2_addr0", recs[0].addr, 32'h8);
      chk("s2_mask0", recs[0].mask, 32'h2);
      chk("s2_lo0", recs[0].data[7:0], 32'hAA);
      chk("s2_addr1", recs[1].addr, 32'h10);
      chk("s2_mask1", recs[1].mask, 32'h2);
    end

    // unpaired odd byte while pend holds an even byte
    recs.delete(); ack_dly = 0; downloading = 1;
    send(25'h004, 8'h44, 1); send(25'h009, 8'hCC, 1);
    chk("s3_wait_hi", ioctl_wait, 32'd1);
    @(negedge clk);
    chk("s3_wait_lo", ioctl_wait, 32'd0);
    finish_dl();
    chk("s3_nreq", recs.size(), 32'd2);
    if (recs.size() >= 2) begin
      chk("s3_addr0", recs[0].addr, 32'h2);
      chk("s3_mask0", recs[0].mask, 32'h2);
      chk("s3_addr1", recs[1].addr, 32'h4);
      chk("s3_mask1", recs[1].mask, 32'h1);
      chk("s3_hi1", recs[1].data[15:8], 32'hCC);
    end

    // PROM byte flushes the pending SDRAM byte
    recs.delete(); proms.delete(); downloading = 1;
    send(25'h0FE, 8'h77, 1); send(25'h105, 8'h5A, 1);
    chk("s4_prom_we", prom_we, 32'd1);
    chk("s4_prom_addr", prom_addr, 32'h105);
    chk("s4_prom_data", prom_data, 32'h5A);
    @(negedge clk);
    chk("s4_prom_pulse", prom_we, 32'd0);
    finish_dl();
    chk("s4_nprom", proms.size(), 32'd1);
    chk("s4_nreq", recs.size(), 32'd1);
    if (recs.size() >= 1) begin
      chk("s4_addr", recs[0].addr, 32'h7F);
      chk("s4_mask", recs[0].mask, 32'h2);
      chk("s4_lo", recs[0].data[7:0], 32'h77);
    end

    // stalled SDRAM, loader ignores ioctl_wait
    recs.delete(); ack_en = 0; downloading = 1;
    send(25'h000, 8'h01, 0); send(25'h002, 8'h02, 0); send(25'h004, 8'h03, 0);
    chk("s5_wait_cnt2", ioctl_wait, 32'd0);
    send(25'h006, 8'h04, 0);
    chk("s5_wait_cnt3", ioctl_wait, 32'd1);
    send(25'h008, 8'h05, 0);
    chk("s5_ovf_lo", ovf, 32'd0);
    send(25'h00A, 8'h06, 0);
    chk("s5_ovf_hi", ovf, 32'd1);
    ack_en = 1;
    repeat (40) @(negedge clk);
    finish_dl();
    chk("s5_nreq", recs.size(), 32'd5);
    seen4 = 0;
    foreach (recs[i]) if (recs[i].addr == 22'd4) seen4 = 1;
    chk("s5_dropped", seen4, 32'd0);

    // reset while a request is outstanding
    recs.delete(); ack_en = 0; downloading = 1;
    send(25'h030, 8'h12, 1); send(25'h031, 8'h34, 1);
    wait_reqs(1);
    chk("s6_ovf_sticky", ovf, 32'd1);
    #2 rst_n = 0;
    #1;
    chk("s6_rst_we", prog.prog_we, 32'd0);
    chk("s6_rst_busy", busy, 32'd0);
    chk("s6_rst_ovf", ovf, 32'd0);
    downloading = 0; ack_en = 1;
    @(negedge clk);
    #3 rst_n = 1;
    recs.delete();
    repeat (10) @(negedge clk);
    chk("s6_no_req", recs.size(), 32'd0);

    // random bursts
    spur = 1;
    for (int b = 0; b < 10; b++) begin
      ack_dly = $urandom_range(0, 3);
      cur = 25'($urandom_range(0, 9'h1F0));
      nb = $urandom_range(5, 30);
      @(negedge clk);
      ioctl_addr = 25'($urandom_range(0, 9'h1FF)); ioctl_wr = 1;
      @(negedge clk);
      ioctl_wr = 0;
      downloading = 1;
      for (int k = 0; k < nb; k++) begin
        case ($urandom_range(0, 9))
          7:       a = cur + 25'($urandom_range(2, 6));
          8, 9:    a = 25'($urandom_range(0, 9'h1FF));
          default: a = cur + 25'd1;
        endcase
        if (a > 25'h1FF) a = 25'h0;
        cur = a;
        send(a, 8'($urandom), 1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      finish_dl();
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
